// File: rtl/matmul_loader_pkg.sv
`default_nettype none
// ============================================================================
//  matmul_loader_pkg : shared types and job geometry for the operand loader
//  Revision: 1.0
// ============================================================================
package matmul_loader_pkg;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        GAP    = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_e;

    localparam int WORDS_PER_MATRIX = 16;
    localparam int JOB_WORDS        = 32;

endpackage : matmul_loader_pkg
`default_nettype wire

// File: rtl/matmul_operand_loader.sv
`default_nettype none
// ============================================================================
//  matmul_operand_loader : streams A then B operands onto the multiplier write
//  bus, then holds start until done.                          Revision: 1.0
// ============================================================================
module matmul_operand_loader
    import matmul_loader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              we1,
    output logic              we2,
    output logic [ADDR_W-1:0] addr_pi,
    output logic [DATA_W-1:0] data_pi,
    output logic              start,
    input  logic              done,
    output logic              busy,
    output logic              err_framing,
    output logic [7:0]        jobs_count
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                err_q, err_d;
    logic [7:0]          jobs_q, jobs_d;
    logic                busy_q, busy_d;
    logic                we1_q, we2_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;

    logic                w_accept;
    logic                w_idx_last;
    logic                w_wr_a, w_wr_b;

    // Ready depends only on state (and reset), never on s_valid.
    assign s_ready    = !reset && ((state_q == LOAD_A) || (state_q == LOAD_B));
    assign w_accept   = s_valid && s_ready;
    assign w_idx_last = (idx_q == '1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        jobs_d  = jobs_q;
        w_wr_a  = 1'b0;
        w_wr_b  = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (w_accept) begin
                    w_wr_a = 1'b1;
                    if (s_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else if (w_idx_last) begin
                        state_d = LOAD_B;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (w_accept) begin
                    w_wr_b = 1'b1;
                    if (w_idx_last) begin
                        // A missing last is flagged but the job still runs.
                        state_d = GAP;
                        idx_d   = '0;
                        if (!s_last) begin
                            err_d = 1'b1;
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = LOAD_A;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            GAP: begin
                state_d = RUN;
            end
            RUN: begin
                if (done) begin
                    state_d = DRAIN;
                    jobs_d  = jobs_q + 8'd1;
                end
            end
            DRAIN: begin
                state_d = LOAD_A;
                idx_d   = '0;
            end
            default: begin
                state_d = LOAD_A;
                idx_d   = '0;
            end
        endcase
        busy_d = !((state_d == LOAD_A) && (idx_d == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
            err_q   <= 1'b0;
            jobs_q  <= 8'd0;
            busy_q  <= 1'b0;
            we1_q   <= 1'b0;
            we2_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            jobs_q  <= jobs_d;
            busy_q  <= busy_d;
            we1_q   <= w_wr_a;
            we2_q   <= w_wr_b;
            if (w_wr_a || w_wr_b) begin
                addr_q <= idx_q;
                data_q <= s_data;
            end
        end
    end

    assign we1         = we1_q;
    assign we2         = we2_q;
    assign addr_pi     = addr_q;
    assign data_pi     = data_q;
    assign start       = (state_q == RUN);
    assign busy        = busy_q;
    assign err_framing = err_q;
    assign jobs_count  = jobs_q;

endmodule : matmul_operand_loader
`default_nettype wire
